// File: rtl/ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pkg: shared fetch widths and the IF/ID entry type.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef IFU_DEFINES_SVH
`define IFU_DEFINES_SVH
`define PC_WIDTH   32
`define XLEN       32
`define INST_WIDTH 32
`endif

package ifu_fetch_pkg;

    typedef struct packed {
        logic [`PC_WIDTH-1:0]   pc;
        logic [`INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    localparam logic [`PC_WIDTH-1:0] PC_STEP = `PC_WIDTH'(4);

    // Redirect targets are forced to word alignment.
    function automatic logic [`PC_WIDTH-1:0] align_pc(input logic [`PC_WIDTH-1:0] addr);
        return {addr[`PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch: single-outstanding instruction fetch with one-entry skid buffer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [`PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_jump_i,
    input  logic [`PC_WIDTH-1:0]   ex_jump_pc_i,
    input  logic                   id_stall_i,
    output logic                   imem_req_o,
    output logic [`PC_WIDTH-1:0]   imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [`INST_WIDTH-1:0] imem_rdata_i,
    output logic                   if_valid_o,
    output logic [`PC_WIDTH-1:0]   if_pc_o,
    output logic [`INST_WIDTH-1:0] if_inst_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state;
    logic [`PC_WIDTH-1:0] pc_q;
    logic [`PC_WIDTH-1:0] req_pc_q;
    logic                 kill_q;
    logic                 skid_valid_q;
    fetch_entry_t         skid_q;
    logic                 out_valid_q;
    fetch_entry_t         out_q;

    logic consume;
    logic out_free;

    assign consume     = out_valid_q & ~id_stall_i;
    assign out_free    = ~out_valid_q | consume;

    assign imem_req_o  = (state == FETCH) & ~ex_jump_i;
    assign imem_addr_o = pc_q;

    assign if_valid_o  = out_valid_q;
    assign if_pc_o     = out_q.pc;
    assign if_inst_o   = out_q.inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
        end else if (state != IDLE && ex_jump_i) begin
            // Redirect wins over gnt, rvalid and consumption alike.
            pc_q         <= align_pc(ex_jump_pc_i);
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            if (state == WAIT && !imem_rvalid_i) begin
                kill_q <= 1'b1;
            end else begin
                kill_q <= 1'b0;
                state  <= FETCH;
            end
        end else begin
            if (consume) begin
                out_valid_q <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_req_o && imem_gnt_i) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + PC_STEP;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill_q) begin
                            kill_q <= 1'b0;
                            state  <= FETCH;
                        end else if (out_free) begin
                            out_q       <= '{pc: req_pc_q, inst: imem_rdata_i};
                            out_valid_q <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            skid_q       <= '{pc: req_pc_q, inst: imem_rdata_i};
                            skid_valid_q <= 1'b1;
                            state        <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!id_stall_i && skid_valid_q) begin
                        out_q        <= skid_q;
                        out_valid_q  <= 1'b1;
                        skid_valid_q <= 1'b0;
                        state        <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch: directed self-checking bench for ifu_fetch.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        ex_jump_i;
    logic [31:0] ex_jump_pc_i;
    logic        id_stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_jump_i     (ex_jump_i),
        .ex_jump_pc_i  (ex_jump_pc_i),
        .id_stall_i    (id_stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ex_jump_i     = 1'b0;
        ex_jump_pc_i  = 32'h0;
        id_stall_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        repeat (2) tick();
        chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("rst_pc",    if_pc_o,             32'h0);
        chk("rst_inst",  if_inst_o,           32'h0);
        chk("rst_req",   {31'b0, imem_req_o}, 32'd0);

        // Reset release, gnt and rvalid held high
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1113;
        rst_n = 1'b1; #1;
        chk("idle_req", {31'b0, imem_req_o}, 32'd0);
        tick();
        chk("c2_req",   {31'b0, imem_req_o}, 32'd1);
        chk("c2_addr",  imem_addr_o,         32'h8000_0000);
        chk("c2_valid", {31'b0, if_valid_o}, 32'd0);
        tick();
        chk("c3_req",   {31'b0, imem_req_o}, 32'd0);
        chk("c3_valid", {31'b0, if_valid_o}, 32'd0);
        tick();
        chk("c4_valid", {31'b0, if_valid_o}, 32'd1);
        chk("c4_pc",    if_pc_o,             32'h8000_0000);
        chk("c4_inst",  if_inst_o,           32'h1111_1113);
        chk("c4_addr",  imem_addr_o,         32'h8000_0004);
        tick();
        chk("c5_valid", {31'b0, if_valid_o}, 32'd0);
        tick();
        chk("c6_valid", {31'b0, if_valid_o}, 32'd1);
        chk("c6_pc",    if_pc_o,             32'h8000_0004);
        chk("c6_addr",  imem_addr_o,         32'h8000_0008);

        // Redirect during FETCH
        ex_jump_i = 1'b1; ex_jump_pc_i = 32'h8000_0102; imem_rvalid_i = 1'b0; #1;
        chk("jf_noreq", {31'b0, imem_req_o}, 32'd0);
        tick();
        ex_jump_i = 1'b0; #1;
        chk("jf_valid", {31'b0, if_valid_o}, 32'd0);
        chk("jf_req",   {31'b0, imem_req_o}, 32'd1);
        chk("jf_addr",  imem_addr_o,         32'h8000_0100);

        // Redirect in WAIT, response three cycles late
        tick();
        chk("jw_wait_req", {31'b0, imem_req_o}, 32'd0);
        ex_jump_i = 1'b1; ex_jump_pc_i = 32'h8000_0200;
        tick();
        ex_jump_i = 1'b0;
        chk("jw_valid0", {31'b0, if_valid_o}, 32'd0);
        tick();
        chk("jw_valid1", {31'b0, if_valid_o}, 32'd0);
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; imem_gnt_i = 1'b0;
        tick();
        imem_rvalid_i = 1'b0; #1;
        chk("jw_valid2", {31'b0, if_valid_o}, 32'd0);
        chk("jw_req",    {31'b0, imem_req_o}, 32'd1);
        chk("jw_addr",   imem_addr_o,         32'h8000_0200);

        // Stall with two responses; second parks in the skid buffer
        imem_gnt_i = 1'b1; id_stall_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
        tick();
        chk("st_valid1", {31'b0, if_valid_o}, 32'd1);
        chk("st_pc1",    if_pc_o,             32'h8000_0200);
        chk("st_inst1",  if_inst_o,           32'h0000_0013);
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0010_0093;
        tick();
        imem_rvalid_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b0; #1;
        chk("st_hold_req", {31'b0, imem_req_o}, 32'd0);
        chk("st_hold_pc",  if_pc_o,             32'h8000_0200);
        chk("st_hold_inst", if_inst_o,          32'h0000_0013);
        tick();
        chk("st_hold_valid", {31'b0, if_valid_o}, 32'd1);
        chk("st_hold_inst2", if_inst_o,           32'h0000_0013);
        id_stall_i = 1'b0;
        tick();
        chk("st_valid2", {31'b0, if_valid_o}, 32'd1);
        chk("st_pc2",    if_pc_o,             32'h8000_0204);
        chk("st_inst2",  if_inst_o,           32'h0010_0093);
        chk("st_addr",   imem_addr_o,         32'h8000_0208);

        // Redirect coincident with rvalid while output is stalled
        id_stall_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCAFE_BABE;
        ex_jump_i = 1'b1; ex_jump_pc_i = 32'h8000_0300; #1;
        chk("jr_valid_pre", {31'b0, if_valid_o}, 32'd1);
        chk("jr_req_pre",   {31'b0, imem_req_o}, 32'd0);
        tick();
        ex_jump_i = 1'b0; imem_rvalid_i = 1'b0; id_stall_i = 1'b0; imem_gnt_i = 1'b0; #1;
        chk("jr_valid", {31'b0, if_valid_o}, 32'd0);
        chk("jr_req",   {31'b0, imem_req_o}, 32'd1);
        chk("jr_addr",  imem_addr_o,         32'h8000_0300);
        tick();
        chk("jr_valid2", {31'b0, if_valid_o}, 32'd0);

        // Reset pulse while a request is outstanding
        imem_gnt_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0BAD_F00D; id_stall_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b0;
        tick();
        chk("rp_valid_pre", {31'b0, if_valid_o}, 32'd1);
        chk("rp_pc_pre",    if_pc_o,             32'h8000_0300);
        chk("rp_inst_pre",  if_inst_o,           32'h0BAD_F00D);
        #2 rst_n = 1'b0;
        #1;
        chk("rp_valid", {31'b0, if_valid_o}, 32'd0);
        chk("rp_pc",    if_pc_o,             32'h0);
        chk("rp_inst",  if_inst_o,           32'h0);
        chk("rp_req",   {31'b0, imem_req_o}, 32'd0);
        #1 rst_n = 1'b1;
        imem_rvalid_i = 1'b1; imem_gnt_i = 1'b0;
        tick();
        chk("rp_valid2", {31'b0, if_valid_o}, 32'd0);
        chk("rp_req2",   {31'b0, imem_req_o}, 32'd1);
        chk("rp_addr",   imem_addr_o,         32'h8000_0000);
        tick();
        chk("rp_valid3", {31'b0, if_valid_o}, 32'd0);
        imem_rvalid_i = 1'b0; id_stall_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-002 SHALL use one clock and an asynchronous, active-low reset (clk, rst_n).
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ex_jump_i, input, 1 bit: EX-stage redirect (branch taken, jal or jalr).
REQ-006 SHALL have port ex_jump_pc_i, input, `PC_WIDTH bits: redirect target.
REQ-007 SHALL have port id_stall_i, input, 1 bit: ID cannot accept the current output.
REQ-008 SHALL have port imem_req_o, output, 1 bit: instruction-memory request.
REQ-009 SHALL have port imem_addr_o, output, `PC_WIDTH bits: request address.
REQ-010 SHALL have port imem_gnt_i, input, 1 bit: request accepted this cycle.
REQ-011 SHALL have port imem_rvalid_i, input, 1 bit: response data valid.
REQ-012 SHALL have port imem_rdata_i, input, 32 bits: instruction word.
REQ-013 SHALL have port if_valid_o, output, 1 bit: IF/ID entry valid.
REQ-014 SHALL have port if_pc_o, output, `PC_WIDTH bits: PC of the IF/ID entry.
REQ-015 SHALL have port if_inst_o, output, 32 bits: instruction of the IF/ID entry.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT and HOLD, with IDLE -> FETCH on the first clock after reset release.
REQ-017 SHALL drive imem_req_o = (state==FETCH) & !ex_jump_i, with imem_addr_o = pc_q.
REQ-018 SHALL, in FETCH on req & gnt, capture req_pc_q <= pc_q, set pc_q <= pc_q+4 (wrapping modulo 2^`PC_WIDTH) and go to WAIT.
REQ-019 SHALL allow at most one outstanding request and SHALL ignore imem_rvalid_i outside WAIT.
REQ-020 SHALL, in WAIT on rvalid with kill_q clear and ex_jump_i low: load {req_pc_q, rdata} into the output register if it is free or being consumed, else into the skid buffer.
REQ-021 SHALL go to FETCH after loading the output register, or to HOLD after loading the skid buffer.
REQ-022 SHALL, in HOLD while id_stall_i is low, move the skid entry into the output register and go to FETCH.
REQ-023 SHALL treat the output register as consumed in any cycle where if_valid_o & !id_stall_i, clearing if_valid_o next cycle unless new data loads.
REQ-024 SHALL, on ex_jump_i in any non-IDLE state, set pc_q <= {ex_jump_pc_i[`PC_WIDTH-1:2], 2'b00}, clear if_valid_o and the skid buffer next cycle, and go to FETCH unless in WAIT.
REQ-025 SHALL, on ex_jump_i in WAIT without same-cycle rvalid, set kill_q and stay in WAIT.
REQ-026 SHALL, on ex_jump_i in WAIT with same-cycle rvalid, discard the response and go to FETCH.
REQ-027 SHALL discard a response arriving with kill_q set, clear kill_q and go to FETCH.
REQ-028 SHALL give ex_jump_i priority over every simultaneous event, including gnt, rvalid and consumption.
REQ-029 SHALL achieve latency gnt (cycle N) -> rvalid (N+1) -> if_valid_o (N+2), for a sustained throughput of one instruction per two cycles.
REQ-030 SHALL hold if_pc_o and if_inst_o stable while if_valid_o & id_stall_i.

Reset
REQ-031 SHALL, on rst_n low, asynchronously set state=IDLE, pc_q=RESET_PC, req_pc_q=0, kill_q=0, skid valid=0 and if_valid_o=0.
REQ-032 SHALL, while rst_n is low, hold if_pc_o=0, if_inst_o=0 and imem_req_o=0.
REQ-033 SHALL, on reset asserted mid-operation, abandon any outstanding request and ignore its later response.

Structure
REQ-034 SHALL take `PC_WIDTH, `XLEN and the instruction width from the shared defines file.
REQ-035 SHALL keep FSM state encoding local to the module.
REQ-036 SHALL be a single module with no sub-module.

Verification
REQ-037 SHALL cover reset release with gnt and rvalid always high -> first req addr 0x8000_0000 in cycle 2; if_valid_o with if_pc_o 0x8000_0000 in cycle 4; next addr 0x8000_0004.
REQ-038 SHALL cover ex_jump_i with target 0x8000_0102 during FETCH -> no request that cycle; next request addr 0x8000_0100; if_valid_o low next cycle.
REQ-039 SHALL cover ex_jump_i in WAIT with rvalid delayed 3 cycles -> response discarded, if_valid_o stays 0, then request to the target.
REQ-040 SHALL cover id_stall_i held for 5 cycles with two responses (0x0000_0013, 0x0010_0093) -> first held stable, second in HOLD, delivered in order after stall release.
REQ-041 SHALL cover ex_jump_i coincident with rvalid and a stalled output -> output and skid cleared, response dropped, FSM in FETCH.
REQ-042 SHALL cover rst_n pulsed low during WAIT -> if_valid_o=0 immediately, late rvalid ignored, fetch restarts at 0x8000_0000.
